booth_divider: RTL and testbench

//   Sequential multi-cycle divider, the inverse of the 8x8 Booth multiplier datapath.

---
 rtl/booth_divider.sv | 220 ++++++++++++++++++++++
 tb/tb_booth_divider.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per cycle plus a sign-fix cycle.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module booth_divider #(
   parameter int unsigned W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2*W-1:0]   dividend,
   input  logic [W-1:0]     divisor,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     quotient,
   output logic [W-1:0]     remainder,
   output logic             ovf,
   output logic             div_zero
);

   localparam int unsigned DW = 2 * W;
   localparam int unsigned RW = W + 1;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [RW-1:0]   dvs_q, dvs_d;
   logic [W-1:0]    dlo_q, dlo_d;
   logic            dz_q, dz_d;
   logic            ov_q, ov_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W-1:0]    quotient_q, quotient_d;
   logic [W-1:0]    remainder_q, remainder_d;
   logic            ovf_q, ovf_d;
   logic            div_zero_q, div_zero_d;

   logic [DW-1:0]   dmag_c;
   logic [RW-1:0]   dvmag_c;
   logic [RW-1:0]   shift_c;
   logic            ge_c;

`ifdef DIV_SIGNED_EN
   logic            sd_q, sd_d;
   logic            sv_q, sv_d;
   logic            neg_c;
   logic [W-1:0]    qfix_c;
   logic [W-1:0]    rfix_c;
   logic            sovf_c;
   localparam logic [W-1:0] Q_POS_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Q_NEG_MAX = {1'b1, {(W-1){1'b0}}};
`endif

   // Operand magnitudes presented at capture
   always_comb begin
`ifdef DIV_SIGNED_EN
      dmag_c  = dividend[DW-1] ? DW'(~dividend + DW'(1)) : dividend;
      dvmag_c = divisor[W-1] ? RW'(~{divisor[W-1], divisor} + RW'(1))
                             : {divisor[W-1], divisor};
`else
      dmag_c  = dividend;
      dvmag_c = {1'b0, divisor};
`endif
   end

   // One restoring step on the partial remainder
   always_comb begin
      shift_c = {rem_q, quo_q[W-1]};
      ge_c    = (shift_c >= dvs_q);
   end

`ifdef DIV_SIGNED_EN
   // Sign restoration and signed range check
   always_comb begin
      neg_c  = sd_q ^ sv_q;
      qfix_c = neg_c ? W'(~quo_q + W'(1)) : quo_q;
      rfix_c = sd_q ? W'(~rem_q + W'(1)) : rem_q;
      sovf_c = neg_c ? (quo_q > Q_NEG_MAX) : (quo_q > Q_POS_MAX);
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN:  if (cnt_q == CW'(W - 1)) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      dlo_d       = dlo_q;
      dz_d        = dz_q;
      ov_d        = ov_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      ovf_d       = ovf_q;
      div_zero_d  = div_zero_q;
      done_d      = 1'b0;
      busy_d      = (state_d == S_RUN) || (state_d == S_FIX);
`ifdef DIV_SIGNED_EN
      sd_d        = sd_q;
      sv_d        = sv_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d = '0;
               rem_d = dmag_c[DW-1:W];
               quo_d = dmag_c[W-1:0];
               dvs_d = dvmag_c;
               dlo_d = dividend[W-1:0];
               dz_d  = (divisor == '0);
               // High half already >= divisor means the quotient needs more than W bits
               ov_d  = ({1'b0, dmag_c[DW-1:W]} >= dvmag_c);
`ifdef DIV_SIGNED_EN
               sd_d  = dividend[DW-1];
               sv_d  = divisor[W-1];
`endif
            end
         end
         S_RUN: begin
            cnt_d = CW'(cnt_q + CW'(1));
            rem_d = ge_c ? W'(shift_c - dvs_q) : W'(shift_c);
            quo_d = {quo_q[W-2:0], ge_c};
         end
         S_FIX: begin
            if (dz_q) begin
               quo_d = '1;
               rem_d = dlo_q;
               ov_d  = 1'b0;
            end else begin
`ifdef DIV_SIGNED_EN
               quo_d = qfix_c;
               rem_d = rfix_c;
               ov_d  = ov_q | sovf_c;
`endif
            end
         end
         S_DONE: begin
            quotient_d  = quo_q;
            remainder_d = rem_q;
            ovf_d       = ov_q;
            div_zero_d  = dz_q;
            done_d      = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         dlo_q       <= '0;
         dz_q        <= 1'b0;
         ov_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         ovf_q       <= 1'b0;
         div_zero_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
         sd_q        <= 1'b0;
         sv_q        <= 1'b0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         dlo_q       <= dlo_d;
         dz_q        <= dz_d;
         ov_q        <= ov_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         ovf_q       <= ovf_d;
         div_zero_q  <= div_zero_d;
`ifdef DIV_SIGNED_EN
         sd_q        <= sd_d;
         sv_q        <= sv_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign ovf       = ovf_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: directed vector table, corner sequences, and random ops against an arithmetic model.
module tb_booth_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy, done, ovf, div_zero;
   logic [7:0]  quotient, remainder;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        o;
      logic        z;
   } vec_t;

   vec_t vt[$];

   booth_divider #(.W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .ovf(ovf), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference: plain integer division, truncating toward zero
   function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r,
                                 output logic o, output logic z);
      int sa, sb, qq, rr;
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      z = (b == 8'd0);
      if (z) begin
         q = 8'hFF; r = a[7:0]; o = 1'b0;
      end else begin
         qq = sa / sb;
         rr = sa % sb;
`ifdef DIV_SIGNED_EN
         o = (qq > 127) || (qq < -128);
`else
         o = (qq > 255);
`endif
         q = 8'(qq);
         r = 8'(rr);
      end
   endfunction

   // Issue one op; optionally pulse start with garbage operands glitch_at cycles after acceptance
   task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int glitch_at, output int lat);
      @(negedge clk);
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (lat < 40) begin
         if (glitch_at != 0 && lat == glitch_at) begin
            start = 1'b1; dividend = ~a; divisor = b + 8'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
         if (done) break;
      end
      start = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                               input logic eo, input logic ez);
      check({tag, " div_zero"}, 32'(div_zero), 32'(ez));
      check({tag, " ovf"}, 32'(ovf), 32'(eo));
      if (!eo) begin
         check({tag, " quotient"}, 32'(quotient), 32'(eq));
         check({tag, " remainder"}, 32'(remainder), 32'(er));
      end
   endtask

   initial begin
      int lat, ndone;
      logic [7:0] eq, er;
      logic eo, ez;
      logic [15:0] ra, rb_a;
      logic [7:0] rb;

`ifdef DIV_SIGNED_EN
      vt.push_back('{16'd100,   8'd7,    8'd14,   8'd2,    1'b0, 1'b0});
      vt.push_back('{16'hFF9C,  8'd7,    8'hF2,   8'hFE,   1'b0, 1'b0});
      vt.push_back('{16'd100,   8'hF9,   8'hF2,   8'h02,   1'b0, 1'b0});
      vt.push_back('{16'hC080,  8'h7F,   8'h80,   8'h00,   1'b0, 1'b0});
      vt.push_back('{16'hC000,  8'h80,   8'h00,   8'h00,   1'b1, 1'b0});
      vt.push_back('{16'd1000,  8'd3,    8'h00,   8'h00,   1'b1, 1'b0});
      vt.push_back('{16'd50,    8'd0,    8'hFF,   8'h32,   1'b0, 1'b1});
      vt.push_back('{16'hFFFF,  8'd1,    8'hFF,   8'h00,   1'b0, 1'b0});
`else
      vt.push_back('{16'hFE01,  8'hFF,   8'hFF,   8'h00,   1'b0, 1'b0});
      vt.push_back('{16'hFF00,  8'hFF,   8'h00,   8'h00,   1'b1, 1'b0});
      vt.push_back('{16'd100,   8'd7,    8'd14,   8'd2,    1'b0, 1'b0});
      vt.push_back('{16'd50,    8'd0,    8'hFF,   8'h32,   1'b0, 1'b1});
      vt.push_back('{16'd1000,  8'd3,    8'h00,   8'h00,   1'b1, 1'b0});
      vt.push_back('{16'h0100,  8'd2,    8'd128,  8'd0,    1'b0, 1'b0});
`endif

      // Reset with start asserted: reset must win
      rst = 1'b1; start = 1'b1; dividend = 16'd100; divisor = 8'd7;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset quotient", 32'(quotient), 32'd0);
      check("reset remainder", 32'(remainder), 32'd0);
      check("reset ovf", 32'(ovf), 32'd0);
      check("reset div_zero", 32'(div_zero), 32'd0);
      @(negedge clk); start = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      check("idle busy", 32'(busy), 32'd0);

      // Directed table
      foreach (vt[i]) begin
         do_op(vt[i].a, vt[i].b, 0, lat);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd10);
         check($sformatf("vec%0d busy at done", i), 32'(busy), 32'd0);
         check_result($sformatf("vec%0d", i), vt[i].q, vt[i].r, vt[i].o, vt[i].z);
      end

      // Results hold after the done pulse
      do_op(16'd100, 8'd7, 0, lat);
      @(posedge clk); #1;
      check("done one-cycle pulse", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("hold quotient", 32'(quotient), 32'd14);
      check("hold remainder", 32'(remainder), 32'd2);

      // Start during RUN is ignored
      do_op(16'd100, 8'd7, 3, lat);
      check("glitch latency", 32'(lat), 32'd10);
      check_result("glitch", 8'd14, 8'd2, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("glitch no restart", 32'(busy), 32'd0);

      // Busy during run, then reset aborts with no done
      @(negedge clk);
      dividend = 16'd1234; divisor = 8'd9; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("busy in run", 32'(busy), 32'd1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("abort busy", 32'(busy), 32'd0);
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort no done", 32'(ndone), 32'd0);

      // Start held high through DONE: next op accepted only in the following IDLE cycle
      @(negedge clk);
      dividend = 16'd100; divisor = 8'd7; start = 1'b1;
      @(posedge clk); #1;
      dividend = 16'd200; divisor = 8'd9;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1; lat++;
         if (done) break;
      end
      check("b2b first latency", 32'(lat), 32'd10);
      check_result("b2b first", 8'd14, 8'd2, 1'b0, 1'b0);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1; lat++;
         start = 1'b0;
         if (done) break;
      end
      check("b2b second latency", 32'(lat), 32'd11);
      model(16'd200, 8'd9, eq, er, eo, ez);
      check_result("b2b second", eq, er, eo, ez);

      // Random ops against the model
      for (int i = 0; i < 150; i++) begin
         rb = 8'($urandom);
         if ($urandom_range(0, 15) == 0) rb = 8'd0;
         if ($urandom_range(0, 1) == 0) begin
            ra = 16'($urandom);
         end else begin
`ifdef DIV_SIGNED_EN
            rb_a = 16'(int'($signed(8'($urandom))) * int'($signed(rb)) + int'($urandom_range(0, 3)));
`else
            rb_a = 16'(int'(8'($urandom)) * int'(rb) + int'($urandom_range(0, 3)));
`endif
            ra = rb_a;
         end
         model(ra, rb, eq, er, eo, ez);
         do_op(ra, rb, 0, lat);
         check($sformatf("rand%0d %h/%h latency", i, ra, rb), 32'(lat), 32'd10);
         check_result($sformatf("rand%0d %h/%h", i, ra, rb), eq, er, eo, ez);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
